// File: rtl/xy_seq_ctrl.sv
// xy_seq_ctrl
//   Stimulus sequencer for a two-input (x,y) -> (z,o) FSM datapath.
//   A small table of {x,y} codes with per-step hold times is written through
//   cfg_*. A start plays the first num_steps entries back-to-back onto x/y,
//   and the z/o outputs of the driven FSM are monitored while busy.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cfg_we/addr/code/hold   table write (dropped while busy)
//   start, num_steps  run request; num_steps sampled with start, clamped to DEPTH
//   abort             end the current run early
//   z, o              FSM outputs being monitored
//   x, y              registered FSM inputs
//   busy, done, aborted, step_idx   run status
//   z_count           saturating count of busy cycles with z=1
//   o_seen            sticky: o=1 seen while busy, cleared by an accepted start
//
// States
//   IDLE | x/y parked at 00, table writable, waiting for start
//   RUN  | playing table steps, counting down each step's hold

module xy_seq_ctrl #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    parameter int ZCNT_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [1:0]        cfg_code,
    input  logic [CNT_W-1:0]  cfg_hold,
    input  logic              start,
    input  logic [AW:0]       num_steps,
    input  logic              abort,
    input  logic              z,
    input  logic              o,
    output logic              x,
    output logic              y,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [AW-1:0]     step_idx,
    output logic [ZCNT_W-1:0] z_count,
    output logic              o_seen
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          code_q [DEPTH];
    logic [1:0]          code_d [DEPTH];
    logic [CNT_W-1:0]    hold_q [DEPTH];
    logic [CNT_W-1:0]    hold_d [DEPTH];
    logic                x_q, x_d, y_q, y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [AW-1:0]       step_idx_q, step_idx_d;
    logic [AW-1:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ZCNT_W-1:0]   z_count_q, z_count_d;
    logic                o_seen_q, o_seen_d;

    logic [AW:0]         n_clamped;
    logic [AW:0]         n_minus1;
    logic [AW-1:0]       next_idx;

    // A hold of 0 still occupies one cycle.
    function automatic logic [CNT_W-1:0] eff_hold(input logic [CNT_W-1:0] h);
        return (h == '0) ? CNT_W'(1) : h;
    endfunction

    assign n_clamped = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    assign n_minus1  = n_clamped - (AW+1)'(1);
    assign next_idx  = step_idx_q + AW'(1);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        hold_d     = hold_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        step_idx_d = step_idx_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        z_count_d  = z_count_q;
        o_seen_d   = o_seen_q;

        // Monitoring uses the registered busy, i.e. the cycles x/y are driven.
        if (busy_q && z && (z_count_q != '1)) begin
            z_count_d = z_count_q + ZCNT_W'(1);
        end
        if (busy_q && o) begin
            o_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    code_d[cfg_addr] = cfg_code;
                    hold_d[cfg_addr] = cfg_hold;
                end
                if (start && !abort) begin
                    if (num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        busy_d     = 1'b1;
                        {x_d, y_d} = code_q[0];
                        cnt_d      = eff_hold(hold_q[0]);
                        step_idx_d = '0;
                        last_idx_d = n_minus1[AW-1:0];
                        z_count_d  = '0;
                        o_seen_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    {x_d, y_d} = 2'b00;
                    step_idx_d = '0;
                    aborted_d  = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (step_idx_q == last_idx_q) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        {x_d, y_d} = 2'b00;
                        step_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        step_idx_d = next_idx;
                        {x_d, y_d} = code_q[next_idx];
                        cnt_d      = eff_hold(hold_q[next_idx]);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= '0;
                hold_q[i] <= '0;
            end
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            step_idx_q <= '0;
            last_idx_q <= '0;
            cnt_q      <= '0;
            z_count_q  <= '0;
            o_seen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            hold_q     <= hold_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            step_idx_q <= step_idx_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            z_count_q  <= z_count_d;
            o_seen_q   <= o_seen_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign step_idx = step_idx_q;
    assign z_count  = z_count_q;
    assign o_seen   = o_seen_q;

endmodule

// File: tb/tb_xy_seq_ctrl.sv
module tb_xy_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [1:0] cfg_code;
    logic [7:0] cfg_hold;
    logic       start;
    logic [2:0] num_steps;
    logic       abort;
    logic       z;
    logic       o;
    logic       x, y, busy, done, aborted, o_seen;
    logic [1:0] step_idx;
    logic [7:0] z_count;

    xy_seq_ctrl #(.DEPTH(4), .CNT_W(8), .ZCNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_code(cfg_code), .cfg_hold(cfg_hold),
        .start(start), .num_steps(num_steps), .abort(abort),
        .z(z), .o(o),
        .x(x), .y(y), .busy(busy), .done(done), .aborted(aborted),
        .step_idx(step_idx), .z_count(z_count), .o_seen(o_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       x;
        logic       y;
        logic       done;
        logic       ab;
        logic [1:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference table and monitor model
    logic [1:0] tcode [4];
    int         thold [4];
    int         zc_model;
    logic       os_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int a, input logic [1:0] c, input int h);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_code = c;
        cfg_hold = 8'(h);
        @(negedge clk);
        cfg_we   = 1'b0;
        tcode[a] = c;
        thold[a] = h;
    endtask

    task automatic push_exp(input logic b, input logic [1:0] c, input logic d,
                            input logic ab, input int idx);
        exp_t e;
        e.busy = b; e.x = c[1]; e.y = c[0]; e.done = d; e.ab = ab; e.idx = 2'(idx);
        q.push_back(e);
    endtask

    // Runs one start with n steps; abort_at/o_at are busy-cycle indices
    // (-1 = never), z is high on cycles [z_from, z_to). junk injects start and
    // cfg_we during busy cycle 1.
    task automatic run(input int n, input int abort_at, input int z_from, input int z_to,
                       input int o_at, input bit junk);
        int   nc;
        int   h;
        int   i;
        exp_t e;
        nc = (n > 4) ? 4 : n;
        q.delete();
        for (int k = 0; k < nc; k++) begin
            h = (thold[k] == 0) ? 1 : thold[k];
            for (int c = 0; c < h; c++) push_exp(1'b1, tcode[k], 1'b0, 1'b0, k);
        end
        if (abort_at >= 0 && abort_at < q.size()) begin
            while (q.size() > abort_at + 1) void'(q.pop_back());
            push_exp(1'b0, 2'b00, 1'b0, 1'b1, 0);
        end else begin
            push_exp(1'b0, 2'b00, 1'b1, 1'b0, 0);
        end
        push_exp(1'b0, 2'b00, 1'b0, 1'b0, 0);

        @(negedge clk);
        start     = 1'b1;
        num_steps = 3'(n);
        @(negedge clk);
        start = 1'b0;
        if (nc > 0) begin
            zc_model = 0;
            os_model = 1'b0;
        end
        i = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'(e.busy));
            chk($sformatf("xy[%0d]", i), 32'({x, y}), 32'({e.x, e.y}));
            chk($sformatf("done[%0d]", i), 32'(done), 32'(e.done));
            chk($sformatf("aborted[%0d]", i), 32'(aborted), 32'(e.ab));
            if (e.busy) chk($sformatf("step_idx[%0d]", i), 32'(step_idx), 32'(e.idx));
            chk($sformatf("z_count[%0d]", i), 32'(z_count), 32'(zc_model));
            chk($sformatf("o_seen[%0d]", i), 32'(o_seen), 32'(os_model));
            abort = (i == abort_at);
            z     = (i >= z_from && i < z_to);
            o     = (i == o_at);
            if (junk && i == 1) begin
                start = 1'b1; num_steps = 3'd1;
                cfg_we = 1'b1; cfg_addr = 2'd2; cfg_code = 2'b00; cfg_hold = 8'd5;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            if (e.busy) begin
                if (z && zc_model < 255) zc_model++;
                if (o) os_model = 1'b1;
            end
            @(negedge clk);
            i++;
        end
        abort = 1'b0; z = 1'b0; o = 1'b0; start = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_code = '0; cfg_hold = '0;
        start = 1'b0; num_steps = '0; abort = 1'b0; z = 1'b0; o = 1'b0;
        for (int k = 0; k < 4; k++) begin tcode[k] = 2'b00; thold[k] = 0; end
        zc_model = 0;
        os_model = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xy", 32'({x, y}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_zc", 32'(z_count), 32'd0);

        // 1. reset mid-run during step 1 of 3
        cfg(0, 2'b01, 3); cfg(1, 2'b10, 2); cfg(2, 2'b11, 1);
        @(negedge clk);
        start = 1'b1; num_steps = 3'd3; z = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_idx", 32'(step_idx), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_xy", 32'({x, y}), 32'd0);
        chk("arst_idx", 32'(step_idx), 32'd0);
        chk("arst_zc", 32'(z_count), 32'd0);
        @(negedge clk);
        rst = 1'b0; z = 1'b0;
        for (int k = 0; k < 4; k++) begin tcode[k] = 2'b00; thold[k] = 0; end
        zc_model = 0;
        run(3, -1, -1, -1, -1, 1'b0);

        // 2. basic playback
        cfg(0, 2'b01, 3); cfg(1, 2'b10, 2); cfg(2, 2'b11, 1);
        run(3, -1, 0, 2, -1, 1'b0);

        // 4. abort in 2nd cycle of step 1; z_count retained
        run(3, 4, 0, 5, -1, 1'b0);

        // 5. start/cfg_we while busy ignored; N=0 start
        run(3, -1, -1, -1, -1, 1'b1);
        run(0, -1, -1, -1, -1, 1'b0);

        // abort and start together in IDLE: nothing happens
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_steps = 3'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("ab_start_busy", 32'(busy), 32'd0);
        chk("ab_start_done", 32'(done), 32'd0);
        chk("ab_start_abt", 32'(aborted), 32'd0);

        // abort on the final step's expiry cycle: aborted wins
        run(3, 5, -1, -1, -1, 1'b0);

        // 3. all holds zero, N=4, then N=6 clamps to 4
        cfg(0, 2'b00, 0); cfg(1, 2'b01, 0); cfg(2, 2'b10, 0); cfg(3, 2'b11, 0);
        run(4, -1, 1, 3, -1, 1'b0);
        run(6, -1, -1, -1, -1, 1'b0);

        // 6. z saturation over 300 busy cycles, o pulse sticky until next start
        cfg(0, 2'b01, 100); cfg(1, 2'b10, 100); cfg(2, 2'b11, 100);
        run(3, -1, 0, 300, 50, 1'b0);
        chk("zc_sat", 32'(z_count), 32'd255);
        chk("o_sticky", 32'(o_seen), 32'd1);
        cfg(0, 2'b10, 2);
        run(1, -1, -1, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
